// File: rtl/tm1638_ctrl_if.sv
// Word-level link between the TM1638 sequencer (master) and the spi byte engine (slave).
interface tm1638_ctrl_if;
  logic        busy;
  logic        data_ready;
  logic [16:0] data;

  modport master (input busy, output data_ready, output data);
  modport slave  (output busy, input data_ready, input data);
endinterface

// File: rtl/tm1638_ctrl.sv
// TM1638 refresh sequencer: keeps a 16-byte display shadow plus brightness/on setting
// and streams CTRL, MODE, ADDR and 16 data words to the spi engine whenever they need pushing.
//
// state       | meaning
// S_IDLE      | nothing in flight; launch on dirty or timer expiry
// S_ISSUE     | waiting for spi idle, then present one word for a single cycle
// S_WAIT_ACK  | word presented, waiting for spi busy to rise
// S_WAIT_DONE | spi working on the word, waiting for busy to fall
module tm1638_ctrl #(
  parameter int unsigned REFRESH_CYCLES  = 1_000_000,
  parameter logic [2:0]  INIT_BRIGHTNESS = 3'd7
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic        i_Wr,
  input  logic [3:0]  i_Wr_Addr,
  input  logic [7:0]  i_Wr_Data,
  input  logic [2:0]  i_Brightness,
  input  logic        i_Display_On,
  output logic        o_Idle,
  tm1638_ctrl_if.master spi
);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_ISSUE     = 2'd1;
  localparam logic [1:0] S_WAIT_ACK  = 2'd2;
  localparam logic [1:0] S_WAIT_DONE = 2'd3;

  localparam logic [4:0] LAST_STEP = 5'd18;
  localparam int TW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

  logic [1:0]    state_q, state_d;
  logic [4:0]    step_q, step_d;
  logic          dirty_q, dirty_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          ready_q, ready_d;
  logic [16:0]   data_q, data_d;
  logic [3:0]    set_q;
  logic [7:0]    shadow_q [16];

  logic          set_chg;
  logic          expire;
  logic [3:0]    data_idx;
  logic [16:0]   word;

  assign set_chg  = ({i_Display_On, i_Brightness} != set_q);
  assign expire   = (REFRESH_CYCLES != 0) && (timer_q == TW'(REFRESH_CYCLES - 1));
  assign data_idx = 4'(step_q - 5'd3);

  // Word content is taken from the live shadow/setting at issue time.
  always_comb begin
    case (step_q)
      5'd0:    word = {1'b1, 8'h00, 4'b1000, set_q};
      5'd1:    word = {1'b1, 8'h00, 8'h40};
      5'd2:    word = {1'b0, 8'h00, 8'hC0};
      default: word = {(step_q == LAST_STEP), 8'h00, shadow_q[data_idx]};
    endcase
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    dirty_d = dirty_q;
    timer_d = timer_q;
    ready_d = 1'b0;
    data_d  = data_q;
    case (state_q)
      S_IDLE: begin
        if (dirty_q || expire) begin
          dirty_d = 1'b0;
          step_d  = '0;
          timer_d = '0;
          state_d = S_ISSUE;
        end else if (REFRESH_CYCLES != 0) begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_ISSUE: begin
        if (!spi.busy) begin
          ready_d = 1'b1;
          data_d  = word;
          state_d = S_WAIT_ACK;
        end
      end
      S_WAIT_ACK: begin
        if (spi.busy) state_d = S_WAIT_DONE;
      end
      default: begin
        if (!spi.busy) begin
          if (step_q == LAST_STEP) begin
            state_d = S_IDLE;
          end else begin
            step_d  = step_q + 5'd1;
            state_d = S_ISSUE;
          end
        end
      end
    endcase
    // A new request landing on the launch cycle must survive the clear above.
    if (i_Wr || set_chg) dirty_d = 1'b1;
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q <= S_IDLE;
      step_q  <= '0;
      dirty_q <= 1'b1;
      timer_q <= '0;
      ready_q <= 1'b0;
      data_q  <= '0;
      set_q   <= {1'b1, INIT_BRIGHTNESS};
      for (int i = 0; i < 16; i++) shadow_q[i] <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      dirty_q <= dirty_d;
      timer_q <= timer_d;
      ready_q <= ready_d;
      data_q  <= data_d;
      set_q   <= {i_Display_On, i_Brightness};
      if (i_Wr) shadow_q[i_Wr_Addr] <= i_Wr_Data;
    end
  end

  assign spi.data_ready = ready_q;
  assign spi.data       = data_q;
  assign o_Idle         = (state_q == S_IDLE) && !dirty_q;

endmodule

// File: tb/tb_tm1638_ctrl.sv
// Scoreboard bench for tm1638_ctrl: a frame-level model predicts every word sent to spi,
// plus a second instance exercising the periodic refresh timer and mid-frame reset.
module tb_tm1638_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0, rst1;
  logic       wr0;
  logic [3:0] addr0;
  logic [7:0] wdata0;
  logic [2:0] br0;
  logic       on0;
  logic       idle0, idle1;

  tm1638_ctrl_if if0();
  tm1638_ctrl_if if1();

  tm1638_ctrl #(.REFRESH_CYCLES(0), .INIT_BRIGHTNESS(3'd7)) dut0 (
    .i_Clk(clk), .i_Rst(rst0), .i_Wr(wr0), .i_Wr_Addr(addr0), .i_Wr_Data(wdata0),
    .i_Brightness(br0), .i_Display_On(on0), .o_Idle(idle0), .spi(if0)
  );

  tm1638_ctrl #(.REFRESH_CYCLES(100), .INIT_BRIGHTNESS(3'd7)) dut1 (
    .i_Clk(clk), .i_Rst(rst1), .i_Wr(1'b0), .i_Wr_Addr(4'd0), .i_Wr_Data(8'd0),
    .i_Brightness(3'd7), .i_Display_On(1'b1), .o_Idle(idle1), .spi(if1)
  );

  // spi engine stand-ins: busy rises the edge after a word strobe and stays high 4 cycles
  logic sbusy0 = 1'b0, sbusy1 = 1'b0, ext_busy = 1'b0;
  int   scnt0 = 0, scnt1 = 0;
  assign if0.busy = sbusy0 | ext_busy;
  assign if1.busy = sbusy1;

  always @(posedge clk) begin
    if (scnt0 != 0) begin
      scnt0 <= scnt0 - 1;
      if (scnt0 == 1) sbusy0 <= 1'b0;
    end else if (if0.data_ready && !sbusy0) begin
      sbusy0 <= 1'b1;
      scnt0  <= 4;
    end
  end

  always @(posedge clk) begin
    if (scnt1 != 0) begin
      scnt1 <= scnt1 - 1;
      if (scnt1 == 1) sbusy1 <= 1'b0;
    end else if (if1.data_ready && !sbusy1) begin
      sbusy1 <= 1'b1;
      scnt1  <= 4;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: a refresh is 19 words; value depends only on the step and current model state.
  function automatic logic [16:0] exp_word(input int k, input logic on, input logic [2:0] br,
                                           input logic [7:0] b);
    if (k == 0) return {1'b1, 8'h00, 4'b1000, on, br};
    if (k == 1) return {1'b1, 8'h00, 8'h40};
    if (k == 2) return {1'b0, 8'h00, 8'hC0};
    return {(k == 18), 8'h00, b};
  endfunction

  logic [7:0] m_sh [16];
  logic       m_on;
  logic [2:0] m_br;
  int         exp_q[$];
  int         last_step0 = -1;
  int         words0 = 0;
  int         k0;

  task automatic push_frame();
    for (int k = 0; k < 19; k++) exp_q.push_back(k);
  endtask

  always @(negedge clk) begin
    if (!rst0 && if0.data_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word0 got %h expected none", if0.data);
      end else begin
        k0 = exp_q.pop_front();
        check("word0", 32'(if0.data),
              32'(exp_word(k0, m_on, m_br, (k0 >= 3) ? m_sh[k0-3] : 8'h00)));
        last_step0 = k0;
        words0++;
      end
    end
  end

  int w1 = 0, last_step1 = -1;
  int run1 = 0, last_run1 = 0, runs1 = 0;

  always @(negedge clk) begin
    if (rst1) begin
      w1 = 0;
    end else if (if1.data_ready) begin
      check("word1", 32'(if1.data), 32'(exp_word(w1, 1'b1, 3'd7, 8'h00)));
      last_step1 = w1;
      w1 = (w1 + 1) % 19;
    end
  end

  always @(negedge clk) begin
    if (idle1) begin
      run1++;
    end else begin
      if (run1 > 0) begin
        last_run1 = run1;
        runs1++;
      end
      run1 = 0;
    end
  end

  task automatic host_write(input logic [3:0] a, input logic [7:0] d);
    wr0 = 1'b1; addr0 = a; wdata0 = d;
    m_sh[a] = d;
    @(posedge clk); #1;
    wr0 = 1'b0;
  endtask

  task automatic set_setting(input logic o, input logic [2:0] b);
    on0 = o; br0 = b;
    m_on = o; m_br = b;
    @(posedge clk); #1;
  endtask

  task automatic wait_idle0(input string name);
    int n;
    repeat (2) @(posedge clk);
    n = 0;
    while (!idle0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!idle0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout got busy expected idle", name);
    end
    @(posedge clk); #1;
    check({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, bad, n, nw;
    logic [2:0] nb;
    logic       no;

    rst0 = 1'b1; rst1 = 1'b1;
    wr0 = 1'b0; addr0 = '0; wdata0 = '0; br0 = 3'd7; on0 = 1'b1;
    m_on = 1'b1; m_br = 3'd7;
    for (int i = 0; i < 16; i++) m_sh[i] = 8'h00;

    repeat (3) @(posedge clk); #1;
    check("rst_idle", 32'(idle0), 32'd0);
    check("rst_ready", 32'(if0.data_ready), 32'd0);
    check("rst_data", 32'(if0.data), 32'd0);

    push_frame();
    rst0 = 1'b0; rst1 = 1'b0;
    wait_idle0("init");
    check("init_words", 32'(words0), 32'd19);

    nw = words0;
    host_write(4'd3, 8'h5B);
    push_frame();
    wait_idle0("write3");
    check("write3_words", 32'(words0 - nw), 32'd19);

    // write landing while data word 5 is in flight forces exactly one more frame
    nw = words0;
    host_write(4'd0, 8'h00);
    push_frame();
    n = 0;
    while (last_step0 != 8 && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    check("mid_reached", 32'(last_step0), 32'd8);
    host_write(4'd15, 8'hFF);
    push_frame();
    wait_idle0("mid");
    repeat (40) @(posedge clk); #1;
    check("mid_words", 32'(words0 - nw), 32'd38);

    set_setting(1'b0, 3'd2);
    push_frame();
    wait_idle0("dim_off");
    set_setting(1'b1, 3'd2);
    push_frame();
    wait_idle0("dim_on");

    // second write coincides with the launch cycle of the first
    nw = words0;
    host_write(4'd1, 8'h11);
    host_write(4'd2, 8'h22);
    push_frame();
    push_frame();
    wait_idle0("coincident");
    check("coincident_words", 32'(words0 - nw), 32'd38);

    ext_busy = 1'b1;
    host_write(4'd4, 8'(32'($urandom)));
    push_frame();
    repeat (2) @(posedge clk);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (if0.data_ready) bad++;
    end
    check("hold_no_ready", 32'(bad), 32'd0);
    @(posedge clk); #1;
    ext_busy = 1'b0;
    wait_idle0("hold");

    for (int it = 0; it < 12; it++) begin
      if ($urandom_range(0, 2) != 0) begin
        host_write(4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
      end else begin
        nb = 3'($urandom_range(0, 7));
        no = 1'($urandom_range(0, 1));
        if ({no, nb} == {m_on, m_br}) nb = nb + 3'd1;
        set_setting(no, nb);
      end
      push_frame();
      wait_idle0("rand");
    end

    // periodic instance: idle stretch between frames is the full timer period
    for (int r = 0; r < 2; r++) begin
      base = runs1;
      n = 0;
      while (runs1 == base && n < 3000) begin
        @(posedge clk); #1;
        n++;
      end
      check("timer_period", 32'(last_run1), 32'd100);
    end

    n = 0;
    while (!(last_step1 == 10 && w1 == 11) && n < 3000) begin
      @(negedge clk); #1;
      n++;
    end
    check("rst_point", 32'(last_step1), 32'd10);
    rst1 = 1'b1;
    @(posedge clk); #1;
    check("rst1_ready", 32'(if1.data_ready), 32'd0);
    check("rst1_data", 32'(if1.data), 32'd0);
    check("rst1_idle", 32'(idle1), 32'd0);
    @(posedge clk); #1;
    rst1 = 1'b0;
    n = 0;
    while (!if1.data_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("rst1_restart", 32'(if1.data), 32'h1008F);
    repeat (5) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
